muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit for the single-cycle core. Sits between register-file read ports and write-back: takes rs1/rs2 operand data plus funct3, stalls the core while it computes, then drives one write-back pulse (address, data, enable) into the register file's write port. Covers all eight M-extension operations, including the ISA-defined divide-by-zero and signed-overflow results.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_iter.sv | 31 +++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    localparam int          ITER_CNT         = 32;
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES         = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              mode,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] diff;

    // mode 0: {hi,lo} holds {partial, multiplier}; mode 1: {remainder, dividend/quotient}
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem  = acc[2*XLEN-1:XLEN-1];
        diff = rem[XLEN-1:0] - operand;
        if (!mode) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else if (rem >= {1'b0, operand}) begin
            acc_next = {diff, acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            rd_wren_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o
);

    localparam logic [4:0] LAST = 5'(ITER_CNT - 1);

    muldiv_state_e     state;
    muldiv_op_e        op_q;
    logic [4:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   opnd;
    logic              neg_res;
    logic              neg_rem;

    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   calc_res;

    assign is_div = op_i[2];
    assign sgn_a  = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU)
                 || (op_i == OP_DIV) || (op_i == OP_REM);
    assign sgn_b  = (op_i == OP_MUL) || (op_i == OP_MULH)
                 || (op_i == OP_DIV) || (op_i == OP_REM);
    assign neg_a  = sgn_a && rs1_data_i[XLEN-1];
    assign neg_b  = sgn_b && rs2_data_i[XLEN-1];
    assign mag_a  = neg_a ? -rs1_data_i : rs1_data_i;
    assign mag_b  = neg_b ? -rs2_data_i : rs2_data_i;

    assign div_zero = is_div && (rs2_data_i == '0);
    assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM))
                   && (rs1_data_i == DIV_OVF_DIVIDEND) && (rs2_data_i == ALL_ONES);

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN:0]          fast_a;
    logic [XLEN:0]          fast_b;
    logic signed [2*XLEN-1:0] fast_prod;

    assign fast_a    = {sgn_a && rs1_data_i[XLEN-1], rs1_data_i};
    assign fast_b    = {sgn_b && rs2_data_i[XLEN-1], rs2_data_i};
    assign fast_prod = $signed(fast_a) * $signed(fast_b);
`endif

    // REM/REMU have funct3[1] set, DIV/DIVU do not
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (div_zero) begin
            special     = 1'b1;
            special_res = op_i[1] ? rs1_data_i : ALL_ONES;
        end else if (div_ovf) begin
            special     = 1'b1;
            special_res = op_i[1] ? '0 : DIV_OVF_DIVIDEND;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!is_div) begin
            special     = 1'b1;
            special_res = (op_i == OP_MUL) ? fast_prod[XLEN-1:0]
                                           : fast_prod[2*XLEN-1:XLEN];
`endif
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .acc      (acc),
        .operand  (opnd),
        .mode     (op_q[2]),
        .acc_next (acc_nxt)
    );

    assign prod = neg_res ? -acc_nxt : acc_nxt;
    assign quot = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    assign rem  = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        calc_res = '0;
        unique case (op_q)
            OP_MUL:                        calc_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               calc_res = quot;
            OP_REM, OP_REMU:               calc_res = rem;
            default:                       calc_res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q      <= muldiv_op_e'(op_i);
                        rd_addr_o <= rd_addr_i;
                        neg_res   <= neg_a ^ neg_b;
                        neg_rem   <= neg_a;
                        cnt       <= '0;
                        acc       <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                        opnd      <= is_div ? mag_b : mag_a;
                        if (special) begin
                            rd_data_o <= special_res;
                            state     <= ST_DONE;
                        end else begin
                            state     <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        rd_data_o <= calc_res;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done_o    = (state == ST_DONE);
    assign rd_wren_o = done_o && (rd_addr_o != 5'd0);
    assign stall_o   = ((state == ST_IDLE) && start_i && !special) || (state == ST_CALC);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops vs. an arithmetic model.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        stall_o;
    logic        done_o;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .rd_wren_o  (rd_wren_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (done_o) pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        int          ia = $signed(a);
        int          ib = $signed(b);
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        bit f;
        f = (op[2] && b == 0)
         || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
        f = f || !op[2];
`endif
        return f;
    endfunction

    // Ends at #1 after the edge leaving DONE (first IDLE cycle).
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input bit hold);
        logic [31:0] exp;
        bit          fast;
        int          lat;
        exp  = ref_model(op, a, b);
        fast = is_fast(op, a, b);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        #1 chk({nm, "_stall_acc"}, 64'(stall_o), 64'(!fast));
        @(posedge clk_i); #1;
        if (!hold) begin
            start_i    = 1'b0;
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            rd_addr_i  = 5'($urandom);
        end
        lat = 0;
        while (!done_o && lat < 40) begin
            if (!stall_o) chk({nm, "_stall_calc"}, 64'(stall_o), 64'd1);
            @(posedge clk_i); #1;
            lat++;
        end
        chk({nm, "_done"}, 64'(done_o), 64'd1);
        chk({nm, "_lat"}, 64'(lat), fast ? 64'd0 : 64'd32);
        chk({nm, "_data"}, 64'(rd_data_o), 64'(exp));
        chk({nm, "_addr"}, 64'(rd_addr_o), 64'(rd));
        chk({nm, "_wren"}, 64'(rd_wren_o), 64'(rd != 5'd0));
        chk({nm, "_stall_done"}, 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        chk({nm, "_pulse_end"}, 64'(done_o), 64'd0);
        chk({nm, "_data_hold"}, 64'(rd_data_o), 64'(exp));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int p0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_wren", 64'(rd_wren_o), 64'd0);
        chk("rst_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_data", 64'(rd_data_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);

        p0 = pulses;
        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b0);
        chk("mul_one_pulse", 64'(pulses - p0), 64'd1);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b0);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, 1'b0);
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, 1'b0);
        run_op("div0", 3'd4, 32'd5, 32'd0, 5'd11, 1'b0);
        run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd12, 1'b0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
        run_op("rd0", 3'd5, 32'd1000, 32'd3, 5'd0, 1'b0);

        // reset while the divider is mid-iteration
        p0 = pulses;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd12345; rs2_data_i = 32'd17;
        rd_addr_i = 5'd15;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("rstcalc_stall", 64'(stall_o), 64'd0);
        chk("rstcalc_addr", 64'(rd_addr_o), 64'd0);
        chk("rstcalc_data", 64'(rd_data_o), 64'd0);
        repeat (40) begin
            @(posedge clk_i); #1;
            if (rd_wren_o) chk("rstcalc_wren", 64'(rd_wren_o), 64'd0);
        end
        chk("rstcalc_no_pulse", 64'(pulses - p0), 64'd0);

        p0 = pulses;
        run_op("b2b_mul", 3'd0, 32'd1234, 32'd5678, 5'd1, 1'b1);
        run_op("b2b_divu", 3'd5, 32'd99999, 32'd123, 5'd2, 1'b0);
        chk("b2b_pulses", 64'(pulses - p0), 64'd2);

        for (int i = 0; i < 200; i++) begin
            run_op("rnd", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom), bit'($urandom_range(0, 3) == 0));
        end
        start_i = 1'b0;
        @(posedge clk_i); #1;
        chk("final_idle", 64'(done_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
